retire_wb_buffer: RTL and testbench
===================================

Name: retire_wb_buffer

Overview:
- Sits between the ROB commit logic and the architectural register file write port.
- Accepts up to two retired results per cycle (lane 0 older than lane 1). Buffers them in program order and drains one per cycle into the register file's single write port.
- Provides a read-side lookup so operand reads can see values retired but not yet written to the register file.
- Drops writes to x0 at enqueue.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width
DEPTH, 4, buffer entries; power of two, >= 2

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
c0_valid  in  1  lane 0 retire valid (older)
c0_rd  in  ADDR_WIDTH  lane 0 destination
c0_data  in  DATA_WIDTH  lane 0 result
c1_valid  in  1  lane 1 retire valid (younger)
c1_rd  in  ADDR_WIDTH  lane 1 destination
c1_data  in  DATA_WIDTH  lane 1 result
commit_ready  out  1  buffer can accept two entries this cycle
wen  out  1  register file write enable (registered)
waddr  out  ADDR_WIDTH  register file write address (registered)
wdata  out  DATA_WIDTH  register file write data (registered)
lk_addr  in  ADDR_WIDTH  lookup register index (combinational)
lk_hit  out  1  a pending write to lk_addr exists
lk_data  out  DATA_WIDTH  youngest pending value for lk_addr; 0 when no hit
idle  out  1  buffer empty and no write in flight

Behaviour:
- Reset (reset=0, asynchronous):
  - count, head and tail pointers = 0; all entry valid bits cleared.
  - wen=0, waddr=0, wdata=0.
  - Outputs: commit_ready=1, idle=1, lk_hit=0.
  - Reset mid-operation discards all buffered entries.
- Storage: circular FIFO of DEPTH entries {rd, data}; head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- commit_ready = (DEPTH - count) >= 2, combinational from registered count only.
  - Any cXX_valid while commit_ready=0 is a protocol violation. Inputs are ignored and the bench asserts.
- Enqueue (edge, commit_ready=1):
  - A lane is accepted iff valid && rd != 0. A lane with rd == 0 is discarded and takes no slot.
  - Lane 0 is written at tail, then lane 1 at the next slot. If only lane 1 is accepted, it goes at tail.
  - tail advances by the number accepted (0..2).
- Dequeue (every edge):
  - If count > 0 at the edge: head entry loads into the output register, wen<=1, head advances.
  - Else wen<=0; waddr/wdata hold their previous values.
  - An entry enqueued at edge N is eligible to pop at edge N+1 at the earliest (no same-edge bypass).
  - Latency with an empty buffer: retire at edge N, wen high after edge N+1, register file written at edge N+2.
- Count update: count_next = count + accepted - pop. Simultaneous enqueue of 2 and pop of 1 at count = DEPTH-2 gives DEPTH-1, which is legal.
- Lookup (combinational):
  - Searches valid FIFO entries and the output register (when wen=1) for rd == lk_addr.
  - Priority: youngest FIFO entry (nearest tail) first, then older entries, then the output register.
  - lk_addr == 0 always gives lk_hit=0.
  - Same-cycle cXX inputs are not searched.
- Ordering: two entries with the same rd drain oldest-first, so the last write wins in the register file.
  - Lane 0 and lane 1 with the same rd in one cycle: lane 1 is younger; lookup returns lane 1 data.
- idle = (count == 0) && !wen.

Test Plan:
1. Reset mid-stream with 3 entries buffered, reset=0 for 1 cycle -> wen=0, commit_ready=1, idle=1. No write from a pre-reset entry appears afterward.
2. Single retire c0 {rd=5, data=0xDEAD_BEEF} into an empty buffer at edge N -> wen=1, waddr=5, wdata=0xDEADBEEF after edge N+1 only. idle returns to 1 after edge N+2.
3. Dual retire every cycle for 4 cycles, rd=1..8, data=rd*0x11 -> commit_ready drops to 0 once count >= DEPTH-1. Writes emerge in order rd=1..8, one per cycle, with no loss or duplication.
4. c0 {rd=0, data=7} with c1 {rd=3, data=9} -> only rd=3 enqueued. count increments by 1; no wen with waddr=0 is ever produced.
5. c0 {rd=4, data=1} and c1 {rd=4, data=2} in one cycle -> lk_addr=4 gives lk_hit=1, lk_data=2. Drain order is waddr=4/wdata=1 then waddr=4/wdata=2. After drain completes, lk_hit=0.
6. Wrap-around: run 3×DEPTH single retires with random rd!=0 and random data -> outputs match a scoreboard FIFO exactly across pointer wrap. lk_data always matches the youngest pending scoreboard value.

Source files
------------

// File: rtl/retire_wb_buffer.sv
// Retire write-back buffer: takes up to two retired results per cycle,
// drains one per cycle into the register file write port, with lookup.
//
// Ports:
//   clock, reset          : clock and async active-low reset
//   c0_* / c1_*           : retire lanes (lane 0 older than lane 1)
//   commit_ready          : room for two entries this cycle
//   wen / waddr / wdata   : registered register file write port
//   lk_addr / lk_hit /
//   lk_data               : lookup of retired but unwritten values
//   idle                  : buffer empty and no write in flight
module retire_wb_buffer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c0_valid,
    input  logic [ADDR_WIDTH-1:0] c0_rd,
    input  logic [DATA_WIDTH-1:0] c0_data,
    input  logic                  c1_valid,
    input  logic [ADDR_WIDTH-1:0] c1_rd,
    input  logic [DATA_WIDTH-1:0] c1_data,
    output logic                  commit_ready,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic                  lk_hit,
    output logic [DATA_WIDTH-1:0] lk_data,
    output logic                  idle
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    localparam cnt_t RDY_MAX = cnt_t'(DEPTH - 2);

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic       acc0, acc1, pop;
    logic [1:0] n_acc;
    ptr_t       slot1;

    assign commit_ready = (count_q <= RDY_MAX);
    assign idle         = (count_q == '0) && !wen_q;
    assign wen          = wen_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        vld_d   = vld_q;
        head_d  = head_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        acc0  = commit_ready && c0_valid && (c0_rd != '0);
        acc1  = commit_ready && c1_valid && (c1_rd != '0);
        n_acc = {1'b0, acc0} + {1'b0, acc1};
        pop   = (count_q != '0);
        slot1 = tail_q + ptr_t'(acc0);

        if (pop) begin
            wen_d         = 1'b1;
            waddr_d       = rd_q[head_q];
            wdata_d       = data_q[head_q];
            vld_d[head_q] = 1'b0;
            head_d        = head_q + ptr_t'(1);
        end

        // Enqueue slots never alias the popped head while ready holds.
        if (acc0) begin
            rd_d[tail_q]   = c0_rd;
            data_d[tail_q] = c0_data;
            vld_d[tail_q]  = 1'b1;
        end
        if (acc1) begin
            rd_d[slot1]   = c1_rd;
            data_d[slot1] = c1_data;
            vld_d[slot1]  = 1'b1;
        end

        tail_d  = tail_q + ptr_t'(n_acc);
        count_d = count_q + cnt_t'(n_acc) - cnt_t'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Walk oldest to youngest so the youngest match overrides;
    // the output register is seeded first as lowest priority.
    ptr_t idx;

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        if (wen_q && (waddr_q == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (vld_q[idx] && (rd_q[idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[idx];
            end
        end
        if (lk_addr == '0) begin
            lk_hit  = 1'b0;
            lk_data = '0;
        end
    end

endmodule

// File: tb/tb_retire_wb_buffer.sv
// Randomized self-checking bench for retire_wb_buffer against a
// queue-based reference model.
module tb_retire_wb_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        c0_valid, c1_valid;
    logic [4:0]  c0_rd, c1_rd;
    logic [31:0] c0_data, c1_data;
    logic        commit_ready;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic        idle;

    retire_wb_buffer #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .c0_valid(c0_valid),
        .c0_rd(c0_rd),
        .c0_data(c0_data),
        .c1_valid(c1_valid),
        .c1_rd(c1_rd),
        .c1_data(c1_data),
        .commit_ready(commit_ready),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .lk_addr(lk_addr),
        .lk_hit(lk_hit),
        .lk_data(lk_data),
        .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    ent_t        mq[$];
    ent_t        wr_log[$];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          lk_force = -1;
    bit          saw_full;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic model_lookup(input logic [4:0] a, output logic h,
                                output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!h && mq[i].rd == a) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
            if (!h && m_wen && m_waddr == a) begin
                h = 1'b1;
                d = m_wdata;
            end
        end
    endtask

    task automatic cyc(input logic v0, input logic [4:0] r0,
                       input logic [31:0] d0, input logic v1,
                       input logic [4:0] r1, input logic [31:0] d1);
        bit   rdy;
        ent_t e;
        logic eh;
        logic [31:0] ed;
        c0_valid = v0; c0_rd = r0; c0_data = d0;
        c1_valid = v1; c1_rd = r1; c1_data = d1;
        if (v0 || v1) chk("proto_ready", 64'(commit_ready), 64'(1));
        rdy = (DEPTH - mq.size()) >= 2;
        @(posedge clock);
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wen   = 1'b1;
            m_waddr = e.rd;
            m_wdata = e.data;
        end else begin
            m_wen = 1'b0;
        end
        if (rdy && v0 && r0 != 0) mq.push_back('{r0, d0});
        if (rdy && v1 && r1 != 0) mq.push_back('{r1, d1});
        #1;
        c0_valid = 1'b0;
        c1_valid = 1'b0;
        chk("wen", 64'(wen), 64'(m_wen));
        chk("waddr", 64'(waddr), 64'(m_waddr));
        chk("wdata", 64'(wdata), 64'(m_wdata));
        chk("ready", 64'(commit_ready),
            64'((DEPTH - mq.size()) >= 2));
        chk("idle", 64'(idle), 64'(mq.size() == 0 && !m_wen));
        chk("x0_write", 64'(wen && waddr == 0), 64'(0));
        if (!commit_ready) saw_full = 1'b1;
        if (wen) wr_log.push_back('{waddr, wdata});
        if (lk_force >= 0) lk_addr = 5'(lk_force);
        else lk_addr = 5'($urandom_range(0, 8));
        #1;
        model_lookup(lk_addr, eh, ed);
        chk("lk_hit", 64'(lk_hit), 64'(eh));
        chk("lk_data", 64'(lk_data), 64'(ed));
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!commit_ready && n < 20) begin
            idle_cyc();
            n++;
        end
        chk("ready_timeout", 64'(commit_ready), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (!idle && n < 40) begin
            idle_cyc();
            n++;
        end
        chk("drain_timeout", 64'(idle), 64'(1));
    endtask

    initial begin
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic        v0, v1;

        reset = 1'b0;
        c0_valid = 0; c0_rd = 0; c0_data = 0;
        c1_valid = 0; c1_rd = 0; c1_data = 0;
        lk_addr = 0;
        saw_full = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wen", 64'(wen), 64'(0));
        chk("rst_waddr", 64'(waddr), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_ready", 64'(commit_ready), 64'(1));
        chk("rst_idle", 64'(idle), 64'(1));
        lk_addr = 5'd3;
        #1;
        chk("rst_lk_hit", 64'(lk_hit), 64'(0));
        reset = 1'b1;

        // Reset mid-stream with three entries buffered.
        cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        chk("t1_buffered", 64'(mq.size()), 64'(3));
        reset = 1'b0;
        #1;
        chk("t1_wen", 64'(wen), 64'(0));
        chk("t1_ready", 64'(commit_ready), 64'(1));
        chk("t1_idle", 64'(idle), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        wr_log.delete();
        repeat (6) idle_cyc();
        chk("t1_no_stale", 64'(wr_log.size()), 64'(0));

        // Single retire latency.
        cyc(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        chk("t2_wen_n", 64'(wen), 64'(0));
        idle_cyc();
        chk("t2_wen_n1", 64'(wen), 64'(1));
        chk("t2_waddr", 64'(waddr), 64'(5));
        chk("t2_wdata", 64'(wdata), 64'hDEAD_BEEF);
        idle_cyc();
        chk("t2_idle", 64'(idle), 64'(1));

        // Dual retire burst, rd 1..8.
        wr_log.delete();
        saw_full = 0;
        for (int i = 1; i <= 8; i += 2) begin
            wait_ready();
            cyc(1, 5'(i), 32'(i * 'h11),
                1, 5'(i + 1), 32'((i + 1) * 'h11));
        end
        drain();
        chk("t3_full_seen", 64'(saw_full), 64'(1));
        chk("t3_count", 64'(wr_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            chk("t3_order_rd", 64'(wr_log[i].rd), 64'(i + 1));
            chk("t3_order_data", 64'(wr_log[i].data),
                64'((i + 1) * 'h11));
        end

        // x0 discard on lane 0.
        wr_log.delete();
        cyc(1, 5'd0, 32'd7, 1, 5'd3, 32'd9);
        drain();
        chk("t4_count", 64'(wr_log.size()), 64'(1));
        if (wr_log.size() > 0) begin
            chk("t4_rd", 64'(wr_log[0].rd), 64'(3));
            chk("t4_data", 64'(wr_log[0].data), 64'(9));
        end

        // Same rd on both lanes.
        wr_log.delete();
        lk_force = 4;
        cyc(1, 5'd4, 32'd1, 1, 5'd4, 32'd2);
        chk("t5_hit", 64'(lk_hit), 64'(1));
        chk("t5_data", 64'(lk_data), 64'(2));
        lk_force = -1;
        drain();
        chk("t5_count", 64'(wr_log.size()), 64'(2));
        if (wr_log.size() == 2) begin
            chk("t5_first", 64'({wr_log[0].rd, wr_log[0].data}),
                64'({5'd4, 32'd1}));
            chk("t5_second", 64'({wr_log[1].rd, wr_log[1].data}),
                64'({5'd4, 32'd2}));
        end
        lk_addr = 5'd4;
        #1;
        chk("t5_hit_after", 64'(lk_hit), 64'(0));

        // Wrap-around with single retires.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wait_ready();
            cyc(1, 5'($urandom_range(1, 7)), $urandom,
                0, 5'd0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle_cyc();
        end

        // Random dual traffic including x0 and same-rd pairs.
        for (int i = 0; i < 80; i++) begin
            v0 = commit_ready && ($urandom_range(0, 3) != 0);
            v1 = commit_ready && ($urandom_range(0, 3) != 0);
            r0 = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            d0 = $urandom;
            d1 = $urandom;
            cyc(v0, r0, d0, v1, r1, d1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
